flp_mac: RTL and testbench

- Parameterised IEEE-754-style floating-point fused multiply-add computing o_p = i_a + i_b * i_c.
- i_a is the accumulator/addend; i_b and i_c are the multiplicands.
- Single-cycle registered datapath: combinational multiply, align, add, normalise and round, with a registered output.
- Serves as the FP32 MAC building block of the vector engine; default parameters give binary32.

---
 rtl/flp_pkg.sv | 46 ++++
 rtl/flp_mac_mul.sv | 47 ++++
 rtl/flp_mac.sv | 170 +++++++++++++++++
 tb/tb_flp_mac.sv | 116 +++++++++++
 4 files changed

// File: rtl/flp_pkg.sv
// Shared helpers for the flp_mac floating-point datapath.
// Format constants are functions of the exponent and fraction widths so every parameterisation shares them.
package flp_pkg;

    localparam int FLP_MAXW = 128;

    function automatic int bias_of(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic int exp_max_of(input int ew);
        return (1 << ew) - 1;
    endfunction

    function automatic logic [FLP_MAXW-1:0] qnan_of(input int ew, input int sw);
        return (FLP_MAXW'(exp_max_of(ew)) << sw) | (FLP_MAXW'(1) << (sw - 1));
    endfunction

    function automatic logic fld_sign(input logic [FLP_MAXW-1:0] x, input int w);
        return x[w-1];
    endfunction

    function automatic logic [FLP_MAXW-1:0] fld_exp(input logic [FLP_MAXW-1:0] x, input int ew, input int sw);
        return (x >> sw) & ((FLP_MAXW'(1) << ew) - FLP_MAXW'(1));
    endfunction

    function automatic logic [FLP_MAXW-1:0] fld_frac(input logic [FLP_MAXW-1:0] x, input int sw);
        return x & ((FLP_MAXW'(1) << sw) - FLP_MAXW'(1));
    endfunction

    // Leading zeros of the low w bits of v; returns w when they are all zero.
    function automatic int lzc(input logic [FLP_MAXW-1:0] v, input int w);
        int   n;
        logic found;
        n     = w;
        found = 1'b0;
        for (int i = FLP_MAXW - 1; i >= 0; i--) begin
            if (!found && (i < w) && v[i]) begin
                n     = w - 1 - i;
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/flp_mac_mul.sv
// Significand multiply for flp_mac: normalised, truncated product with sticky, plus product exponent and sign.
// Denormal operands are flushed to zero, which makes the significand product zero.
module flp_mac_mul
    import flp_pkg::*;
#(
    parameter int EWIDTH  = 8,
    parameter int SWIDTH  = 23,
    parameter int RSWIDTH = 23,
    parameter int DW      = EWIDTH + 3
) (
    input  logic [EWIDTH+SWIDTH:0] i_b,
    input  logic [EWIDTH+SWIDTH:0] i_c,
    output logic                   o_sign,
    output logic signed [DW-1:0]   o_exp,
    output logic [RSWIDTH:0]       o_sig,
    output logic                   o_sticky
);

    localparam int W    = EWIDTH + SWIDTH + 1;
    localparam int PW   = 2 * SWIDTH + 2;
    localparam int DROP = PW - (RSWIDTH + 1);
    localparam logic [PW-1:0] DROP_MASK = (PW'(1) << DROP) - PW'(1);
    localparam logic [DW-1:0] BIAS_X    = DW'(bias_of(EWIDTH));

    logic [EWIDTH-1:0] eb, ec;
    logic [SWIDTH-1:0] fb, fc;
    logic [SWIDTH:0]   mb, mc;
    logic [PW-1:0]     prod, prod_n;

    assign eb = EWIDTH'(fld_exp(FLP_MAXW'(i_b), EWIDTH, SWIDTH));
    assign ec = EWIDTH'(fld_exp(FLP_MAXW'(i_c), EWIDTH, SWIDTH));
    assign fb = SWIDTH'(fld_frac(FLP_MAXW'(i_b), SWIDTH));
    assign fc = SWIDTH'(fld_frac(FLP_MAXW'(i_c), SWIDTH));

    always_comb begin
        mb     = (eb != '0) ? {1'b1, fb} : '0;
        mc     = (ec != '0) ? {1'b1, fc} : '0;
        prod   = PW'(mb) * PW'(mc);
        // A product in [1,2) has its leading one one place lower; move it to the top bit.
        prod_n = prod[PW-1] ? prod : (prod << 1);
        o_sig    = prod_n[PW-1 -: RSWIDTH+1];
        o_sticky = |(prod_n & DROP_MASK);
        o_exp    = DW'(eb) + DW'(ec) - BIAS_X + DW'(prod[PW-1]);
        o_sign   = fld_sign(FLP_MAXW'(i_b), W) ^ fld_sign(FLP_MAXW'(i_c), W);
    end

endmodule

// File: rtl/flp_mac.sv
// Single-cycle fused multiply-add o_p = i_a + i_b * i_c with round-to-nearest-even and a registered result.
// No handshake: operands are sampled on every rising edge and the result appears after that edge.
module flp_mac
    import flp_pkg::*;
#(
    parameter int EWIDTH  = 8,
    parameter int SWIDTH  = 23,
    parameter int RSWIDTH = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EWIDTH+SWIDTH:0] i_a,
    input  logic [EWIDTH+SWIDTH:0] i_b,
    input  logic [EWIDTH+SWIDTH:0] i_c,
    output logic [EWIDTH+SWIDTH:0] o_p
);

    localparam int W     = EWIDTH + SWIDTH + 1;
    localparam int FW    = (SWIDTH > RSWIDTH) ? SWIDTH : RSWIDTH;
    localparam int XW    = FW + 4;
    localparam int DW    = EWIDTH + 3;
    localparam int RW    = SWIDTH + 2;
    localparam int LOW_W = XW - SWIDTH - 2;
    localparam logic [XW-1:0]        LOW_MASK = (XW'(1) << LOW_W) - XW'(1);
    localparam logic signed [DW-1:0] EMAX_X   = DW'(exp_max_of(EWIDTH));
    localparam logic signed [DW-1:0] ZERO_X   = '0;
    localparam logic [W-1:0]         QNAN_W   = W'(qnan_of(EWIDTH, SWIDTH));

    logic              sa, sb, sc;
    logic [EWIDTH-1:0] ea, eb, ec;
    logic [SWIDTH-1:0] fa, fb, fc;
    logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, c_zero, c_inf, c_nan;
    logic p_zero, p_inf, nan_res;

    logic                 p_sign, p_sticky;
    logic signed [DW-1:0] p_exp;
    logic [RSWIDTH:0]     p_sig;

    logic [XW-1:0]        a_x, p_x, big_x, small_x, small_al, norm;
    logic signed [DW-1:0] ea_x, big_e, small_e, norm_e, res_e;
    logic [DW-1:0]        shift_d;
    logic                 a_big, big_s, small_s, eff_sub;
    logic [XW:0]          sum;
    int                   lz;
    logic [SWIDTH:0]      kept;
    logic                 guard, sticky_r, round_up;
    logic [RW-1:0]        rounded;
    logic [SWIDTH-1:0]    frac_r;
    logic [W-1:0]         res_w;
    logic [W-1:0]         o_p_d, o_p_q;

    assign sa = fld_sign(FLP_MAXW'(i_a), W);
    assign sb = fld_sign(FLP_MAXW'(i_b), W);
    assign sc = fld_sign(FLP_MAXW'(i_c), W);
    assign ea = EWIDTH'(fld_exp(FLP_MAXW'(i_a), EWIDTH, SWIDTH));
    assign eb = EWIDTH'(fld_exp(FLP_MAXW'(i_b), EWIDTH, SWIDTH));
    assign ec = EWIDTH'(fld_exp(FLP_MAXW'(i_c), EWIDTH, SWIDTH));
    assign fa = SWIDTH'(fld_frac(FLP_MAXW'(i_a), SWIDTH));
    assign fb = SWIDTH'(fld_frac(FLP_MAXW'(i_b), SWIDTH));
    assign fc = SWIDTH'(fld_frac(FLP_MAXW'(i_c), SWIDTH));

    always_comb begin
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        c_zero  = (ec == '0);
        a_inf   = (ea == '1) && (fa == '0);
        b_inf   = (eb == '1) && (fb == '0);
        c_inf   = (ec == '1) && (fc == '0);
        a_nan   = (ea == '1) && (fa != '0);
        b_nan   = (eb == '1) && (fb != '0);
        c_nan   = (ec == '1) && (fc != '0);
        p_inf   = b_inf | c_inf;
        p_zero  = b_zero | c_zero;
        nan_res = a_nan | b_nan | c_nan | (b_inf & c_zero) | (c_inf & b_zero)
                | (a_inf & p_inf & (sa != p_sign));
    end

    flp_mac_mul #(
        .EWIDTH (EWIDTH),
        .SWIDTH (SWIDTH),
        .RSWIDTH(RSWIDTH),
        .DW     (DW)
    ) u_mul (
        .i_b     (i_b),
        .i_c     (i_c),
        .o_sign  (p_sign),
        .o_exp   (p_exp),
        .o_sig   (p_sig),
        .o_sticky(p_sticky)
    );

    // Both operands share one layout: integer bit, FW fraction bits, then guard, round, sticky.
    always_comb begin
        a_x     = a_zero ? '0 : (XW'({1'b1, fa}) << (FW - SWIDTH + 3));
        p_x     = (XW'(p_sig) << (FW - RSWIDTH + 3)) | XW'(p_sticky);
        ea_x    = DW'(ea);
        a_big   = !a_zero && ((ea_x > p_exp) || ((ea_x == p_exp) && (a_x >= p_x)));
        big_x   = a_big ? a_x : p_x;
        small_x = a_big ? p_x : a_x;
        big_e   = a_big ? ea_x : p_exp;
        small_e = a_big ? p_exp : ea_x;
        big_s   = a_big ? sa : p_sign;
        small_s = a_big ? p_sign : sa;
        shift_d = DW'(big_e - small_e);
        if (shift_d >= DW'(XW)) begin
            small_al = XW'(|small_x);
        end else begin
            small_al = (small_x >> shift_d) | XW'(|(small_x & ~({XW{1'b1}} << shift_d)));
        end
    end

    always_comb begin
        eff_sub = big_s ^ small_s;
        sum     = eff_sub ? ({1'b0, big_x} - {1'b0, small_al})
                          : ({1'b0, big_x} + {1'b0, small_al});
        lz      = 0;
        if (sum[XW]) begin
            norm   = sum[XW:1] | XW'(sum[0]);
            norm_e = big_e + DW'(1);
        end else begin
            lz     = lzc(FLP_MAXW'(sum[XW-1:0]), XW);
            norm   = sum[XW-1:0] << lz;
            norm_e = big_e - DW'(lz);
        end
    end

    always_comb begin
        kept     = norm[XW-1 -: SWIDTH+1];
        guard    = norm[LOW_W];
        sticky_r = |(norm & LOW_MASK);
        round_up = guard & (sticky_r | kept[0]);
        rounded  = {1'b0, kept} + RW'(round_up);
        // Rounding 1.11..1 up carries into a new integer bit.
        res_e    = rounded[SWIDTH+1] ? (norm_e + DW'(1)) : norm_e;
        frac_r   = rounded[SWIDTH+1] ? rounded[SWIDTH:1] : rounded[SWIDTH-1:0];
        if (sum == '0) begin
            res_w = '0;
        end else if (res_e >= EMAX_X) begin
            res_w = {big_s, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
        end else if (res_e <= ZERO_X) begin
            res_w = {big_s, {(W-1){1'b0}}};
        end else begin
            res_w = {big_s, res_e[EWIDTH-1:0], frac_r};
        end
    end

    always_comb begin
        o_p_d = res_w;
        if (nan_res) begin
            o_p_d = QNAN_W;
        end else if (a_inf) begin
            o_p_d = {sa, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
        end else if (p_inf) begin
            o_p_d = {p_sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
        end else if (p_zero) begin
            o_p_d = a_zero ? {sa & p_sign, {(W-1){1'b0}}} : i_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_p_q <= '0;
        end else begin
            o_p_q <= o_p_d;
        end
    end

    assign o_p = o_p_q;

endmodule

// File: tb/tb_flp_mac.sv
// Directed bench for flp_mac in binary32: hand-computed vectors pushed to an expected queue and checked 1 cycle later.
module tb_flp_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_a, i_b, i_c;
    logic [31:0] o_p;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] V1_A = 32'h401a3237, V1_B = 32'h3eae76d1, V1_C = 32'h3ee9c749, V1_P = 32'h40242756;
    localparam logic [31:0] V2_A = 32'hbe1b902b, V2_B = 32'h3fa40b3b, V2_C = 32'hbea63e5b, V2_P = 32'hbf116b48;

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    flp_mac #(
        .EWIDTH (8),
        .SWIDTH (23),
        .RSWIDTH(23)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_a(i_a),
        .i_b(i_b),
        .i_c(i_c),
        .o_p(o_p)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    // Drive one operation at the falling edge and check it 1 time unit after the next rising edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                         input logic r, input logic [31:0] want, input string tag);
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_c = c;
        rst = r;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        check_eq(tag, o_p, exp_q.pop_front());
    endtask

    initial begin
        rst = 1'b1;
        i_a = $urandom;
        i_b = $urandom;
        i_c = $urandom;

        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, 1'b1, 32'h00000000, "reset_hold");
        end

        drive(V1_A, V1_B, V1_C, 1'b0, V1_P, "vec1");
        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("vec1_held", o_p, V1_P);
        drive(V2_A, V2_B, V2_C, 1'b0, V2_P, "vec2");

        drive(32'h3f800000, 32'h3f800000, 32'hbf800000, 1'b0, 32'h00000000, "cancel");
        drive(32'h40490fdb, 32'h00000000, 32'h12345678, 1'b0, 32'h40490fdb, "prod_zero");
        drive(32'h00000000, 32'h7f000000, 32'h7f000000, 1'b0, 32'h7f800000, "overflow");
        drive(32'h00000000, 32'h7f000000, 32'hff000000, 1'b0, 32'hff800000, "overflow_neg");
        drive(32'h00000000, 32'h7f800000, 32'h00000000, 1'b0, 32'h7fc00000, "inf_times_0");
        drive(32'h7f800000, 32'h3f800000, 32'hff800000, 1'b0, 32'h7fc00000, "inf_minus_inf");
        drive(32'h7f800000, 32'h3f800000, 32'h3f800000, 1'b0, 32'h7f800000, "inf_prop");
        drive(32'h7fc00001, 32'h3f800000, 32'h3f800000, 1'b0, 32'h7fc00000, "nan_in");
        drive(32'h80000000, 32'h80000000, 32'h3f800000, 1'b0, 32'h80000000, "neg_zero");
        drive(32'h80000000, 32'h00000000, 32'h3f800000, 1'b0, 32'h00000000, "mixed_zero");
        drive(32'h00000001, 32'h00000000, 32'h3f800000, 1'b0, 32'h00000000, "denorm_flush");
        drive(32'h00000000, 32'h00800000, 32'h00800000, 1'b0, 32'h00000000, "underflow");
        drive(32'h00000000, 32'h40000000, 32'h40400000, 1'b0, 32'h40c00000, "product_only");
        drive(32'h3f800000, 32'h3f800000, 32'h3f800000, 1'b0, 32'h40000000, "carry_out");
        drive(32'h3f800000, 32'h30800000, 32'h3f800000, 1'b0, 32'h3f800000, "far_sticky");
        drive(32'h3f800000, 32'h33800000, 32'h3f800000, 1'b0, 32'h3f800000, "tie_even_down");
        drive(32'h3f800000, 32'h34400000, 32'h3f800000, 1'b0, 32'h3f800002, "tie_even_up");
        drive(32'h3f800000, 32'h33c00000, 32'h3f800000, 1'b0, 32'h3f800001, "above_half");
        drive(32'h3f800000, 32'hb3800000, 32'h3f800000, 1'b0, 32'h3f7fffff, "sub_renorm");
        drive(32'h3f7fffff, 32'h33000000, 32'h3f800000, 1'b0, 32'h3f800000, "round_carry");

        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) drive(V1_A, V1_B, V1_C, 1'b0, V1_P, "b2b_vec1");
            else            drive(V2_A, V2_B, V2_C, 1'b0, V2_P, "b2b_vec2");
        end
        drive(V1_A, V1_B, V1_C, 1'b1, 32'h00000000, "mid_reset");
        drive(V2_A, V2_B, V2_C, 1'b0, V2_P, "after_reset");
        drive(V1_A, V1_B, V1_C, 1'b0, V1_P, "after_reset_vec1");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
